// File: rtl/counter_updown_mod.sv
// Modulo-MOD up/down counter with synchronous load (clamped to MOD-1),
// combinational terminal count and an optional sticky wrap flag (COUNTER_UPDOWN_OVF_STICKY_EN).
module counter_updown_mod #(
    parameter int N   = 3,
    parameter int MOD = 2**N
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] counter,
    output logic         tc,
    output logic         ovf
);

    // Modulus held one bit wider so MOD = 2**N is representable for the clamp compare.
    localparam logic [N:0]   MOD_W = (N+1)'(MOD);
    localparam logic [N-1:0] TOP   = N'(MOD - 1);

    logic [N-1:0] counter_q;
    logic [N-1:0] counter_nxt;
    logic [N-1:0] load_val;
    logic         at_top;
    logic         at_zero;

    assign at_top   = (counter_q == TOP);
    assign at_zero  = (counter_q == '0);
    assign load_val = ({1'b0, d} >= MOD_W) ? TOP : d;

    // tc is high exactly when the coming edge performs a wrap.
    assign tc = en & ~load & ((up & at_top) | (~up & at_zero));

    always_comb begin
        counter_nxt = counter_q;
        if (load) begin
            counter_nxt = load_val;
        end else if (en) begin
            if (up) begin
                counter_nxt = at_top ? '0 : counter_q + N'(1);
            end else begin
                counter_nxt = at_zero ? TOP : counter_q - N'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_nxt;
        end
    end

    assign counter = counter_q;

`ifdef COUNTER_UPDOWN_OVF_STICKY_EN
    logic ovf_q;

    // Set by any wrap; only reset clears it, a load leaves it alone.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ovf_q <= 1'b0;
        end else if (tc) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: MOD=6 and MOD=8 instances share stimulus; table vectors,
// corner sequences and random traffic checked against an arithmetic reference model.
module tb_counter_updown_mod;

    logic       clk;
    logic       clr_n;
    logic       en;
    logic       up;
    logic       load;
    logic [2:0] d;
    logic [2:0] counter6;
    logic       tc6;
    logic       ovf6;
    logic [2:0] counter8;
    logic       tc8;
    logic       ovf8;

    int n_cmp;
    int n_fail;

    // reference model state
    int  m6;
    int  m8;
    bit  movf6;
    bit  movf8;
    logic [2:0] exp_q[$];
    logic [2:0] exp8_q[$];

`ifdef COUNTER_UPDOWN_OVF_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    counter_updown_mod #(.N(3), .MOD(6)) dut6 (
        .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load), .d(d),
        .counter(counter6), .tc(tc6), .ovf(ovf6)
    );

    counter_updown_mod #(.N(3), .MOD(8)) dut8 (
        .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load), .d(d),
        .counter(counter8), .tc(tc8), .ovf(ovf8)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    // model rules
    function automatic int next_val(int c, int m, bit l, bit e, bit u, int dv);
        if (l) return (dv >= m) ? m - 1 : dv;
        if (!e) return c;
        if (u) return (c + 1) % m;
        return (c + m - 1) % m;
    endfunction

    function automatic bit tc_val(int c, int m, bit l, bit e, bit u);
        return e && !l && (u ? (c == m - 1) : (c == 0));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // one clock of stimulus: check tc before the edge, counter/ovf after it
    task automatic apply(input bit l, input bit e, input bit u, input logic [2:0] dv);
        bit t6;
        bit t8;
        load = l; en = e; up = u; d = dv;
        #2;
        t6 = tc_val(m6, 6, l, e, u);
        t8 = tc_val(m8, 8, l, e, u);
        check("tc6", tc6, t6);
        check("tc8", tc8, t8);
        @(posedge clk);
        movf6 = movf6 | (t6 & STICKY);
        movf8 = movf8 | (t8 & STICKY);
        m6 = next_val(m6, 6, l, e, u, dv);
        m8 = next_val(m8, 8, l, e, u, dv);
        exp_q.push_back(3'(m6));
        exp8_q.push_back(3'(m8));
        #1;
        check("counter6", counter6, exp_q.pop_front());
        check("counter8", counter8, exp8_q.pop_front());
        check("ovf6", ovf6, movf6);
        check("ovf8", ovf8, movf8);
    endtask

    task automatic model_reset();
        m6 = 0; m8 = 0; movf6 = 0; movf8 = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_counter6"}, counter6, 0);
        check({tag, "_counter8"}, counter8, 0);
        check({tag, "_ovf6"}, ovf6, 0);
        check({tag, "_ovf8"}, ovf8, 0);
    endtask

    typedef struct {
        bit         l;
        bit         e;
        bit         u;
        logic [2:0] dv;
        int         exp_cnt;
        bit         exp_tc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n_cmp = 0; n_fail = 0;
        model_reset();
        clr_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; d = '0;

        // scenario 1: up count through the wrap at 5
        for (int i = 1; i <= 8; i++)
            vecs.push_back('{0, 1, 1, 3'd0, i % 6, (i == 6)});
        // scenario 2: load 2 then count down through the wrap at 0
        vecs.push_back('{1, 0, 0, 3'd2, 2, 0});
        vecs.push_back('{0, 1, 0, 3'd0, 1, 0});
        vecs.push_back('{0, 1, 0, 3'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 3'd0, 5, 1});
        vecs.push_back('{0, 1, 0, 3'd0, 4, 0});
        // scenario 3: clamp, then load beats en
        vecs.push_back('{1, 0, 0, 3'd7, 5, 0});
        vecs.push_back('{1, 1, 1, 3'd3, 3, 0});
        // hold and immediate direction change
        vecs.push_back('{0, 0, 1, 3'd6, 3, 0});
        vecs.push_back('{0, 0, 0, 3'd1, 3, 0});
        vecs.push_back('{0, 1, 1, 3'd0, 4, 0});
        vecs.push_back('{0, 1, 0, 3'd0, 3, 0});
        vecs.push_back('{0, 1, 1, 3'd0, 4, 0});

        #12;
        check_reset_state("reset");
        check("reset_tc6", tc6, 0);
        #8;
        clr_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].l, vecs[i].e, vecs[i].u, vecs[i].dv);
            check($sformatf("vec%0d_counter", i), counter6, vecs[i].exp_cnt);
        end
        check("ovf_after_wraps", ovf6, STICKY);

        // scenario 4: async clear mid-count
        apply(1, 0, 0, 3'd3);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #3;
        clr_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("midclr");
        en = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("clrhold");
        check("clrhold_tc6", tc6, 0);
        #3;
        clr_n = 1'b1;
        apply(0, 1, 1, 3'd0);
        check("post_clr_counter", counter6, 1);

        // scenario 5: sticky flag survives load, cleared by reset
        apply(1, 0, 0, 3'd5);
        apply(0, 1, 1, 3'd0);
        check("ovf_set", ovf6, STICKY);
        apply(1, 0, 0, 3'd1);
        check("ovf_after_load", ovf6, STICKY);
        clr_n = 1'b0; en = 1'b0; load = 1'b0;
        #1;
        model_reset();
        check("ovf_cleared", ovf6, 0);
        #4;
        clr_n = 1'b1;

        // scenario 6: MOD=8 natural roll-over and hold at 4
        apply(1, 0, 0, 3'd7);
        apply(0, 1, 1, 3'd0);
        check("mod8_wrap", counter8, 0);
        for (int i = 0; i < 4; i++) apply(0, 1, 1, 3'd0);
        check("mod8_at4", counter8, 4);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 3'd0);
            check("mod8_hold", counter8, 4);
            check("mod8_hold_tc", tc8, 0);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                en = 1'b0; load = 1'b0;
                #1;
                clr_n = 1'b0;
                #1;
                model_reset();
                check_reset_state("rand_clr");
                #2;
                clr_n = 1'b1;
            end
            apply($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_updown_mod.md
COUNTER_UPDOWN_MOD -- requirements
Module: counter_updown_mod

Interface
REQ-001 The block SHALL have parameter N, default 3: counter width in bits.
REQ-002 The block SHALL have parameter MOD, default 2**N: modulus, legal range 2..2**N.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 The block SHALL have port d, input, N bits: load value.
REQ-009 The block SHALL have port counter, output, N bits: registered count value.
REQ-010 The block SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-011 The block SHALL have port ovf, output, 1 bit: sticky wrap flag, registered (see Configuration).

Function
REQ-012 The counter SHALL only ever hold values in 0..MOD-1.
REQ-013 The per-edge update priority SHALL be: clr_n low, then load, then en, then hold.
REQ-014 With load=1, the counter SHALL take d on the next edge, regardless of en and up.
REQ-015 If load=1 and d >= MOD, the counter SHALL take MOD-1 (clamp), never an illegal value.
REQ-016 With load=0, en=1, up=1 and counter < MOD-1, the counter SHALL increment by 1.
REQ-017 With load=0, en=1, up=1 and counter = MOD-1, the counter SHALL wrap to 0.
REQ-018 With load=0, en=1, up=0 and counter > 0, the counter SHALL decrement by 1.
REQ-019 With load=0, en=1, up=0 and counter = 0, the counter SHALL wrap to MOD-1.
REQ-020 With load=0 and en=0, the counter SHALL hold its value.
REQ-021 tc SHALL equal en AND NOT load AND ((up AND counter = MOD-1) OR (NOT up AND counter = 0)), i.e. high exactly in cycles whose edge performs a wrap.
REQ-022 A direction change SHALL take effect on the same edge it is sampled; no turnaround cycle.
REQ-023 When MOD = 2**N, the wrap SHALL be the natural binary roll-over, with identical tc behaviour.
REQ-024 Latency from any input change to counter SHALL be one clock edge; tc SHALL have zero latency.

Reset
REQ-025 While clr_n=0, counter SHALL be 0 and ovf SHALL be 0, immediately and independent of clk.
REQ-026 clr_n asserted mid-count SHALL abort the count; no partial update or load survives.
REQ-027 On the first rising edge after clr_n deasserts, the block SHALL apply normal load/en rules from counter=0.
REQ-028 During reset, tc SHALL still follow REQ-021 with counter=0 (en=1, up=0 gives tc=1); the bench SHALL drive en=0 during reset.

Configuration
REQ-029 The macro COUNTER_UPDOWN_OVF_STICKY_EN SHALL control the sticky overflow feature.
REQ-030 With COUNTER_UPDOWN_OVF_STICKY_EN defined, ovf SHALL be set on any edge where tc=1 and SHALL stay set until clr_n=0; load does not clear it.
REQ-031 With COUNTER_UPDOWN_OVF_STICKY_EN undefined, ovf SHALL be tied to constant 0, with no register inferred; all other behaviour SHALL be unchanged.

Verification (N=3, MOD=6 unless stated)
REQ-032 Scenario 1: clr_n=0 for 20 time units, then en=1, up=1 for 8 edges -> counter sequence 0,1,2,3,4,5,0,1,2; tc=1 only while counter=5.
REQ-033 Scenario 2: load=1, d=2, then en=1, up=0 for 4 edges -> counter 2,1,0,5,4; tc=1 only while counter=0.
REQ-034 Scenario 3: load=1, d=7 -> counter=5; then load=1 and en=1 together with d=3 -> counter=3 (load wins), tc=0.
REQ-035 Scenario 4: counting up at counter=3, pull clr_n low mid-cycle -> counter=0 before the next edge; release, then en=1 -> counter=1 after one edge.
REQ-036 Scenario 5: with the macro defined, wrap once -> ovf=1; load d=1 -> ovf stays 1; clr_n=0 -> ovf=0. With the macro undefined -> ovf=0 throughout.
REQ-037 Scenario 6: N=3, MOD=8, en=1, up=1 from 7 -> counter=0, tc=1 at 7; en=0 at counter=4 for 3 edges -> counter holds 4 and tc=0.
